trace_frame_tx: RTL

TPIU-style 4-bit DDR trace port transmitter, the emitting end of the Orbtrace trace input path. Accepts a byte stream over a valid/ready handshake and packs it into 16-byte frames in a ping-pong buffer. Drives traceDout/traceClkOut with one nibble per trace clock edge. Inserts 0x7FFFFFFF sync words after reset, when idle, and periodically. Used as an on-chip trace source for hardware loopback against the receiver and for bring-up without a target.

---
 rtl/trace_frame_tx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/trace_frame_tx.sv
// TPIU-style 4-bit DDR trace transmitter: ping-pong 16-byte frame buffers, sync insertion.
// Optional macro TRACE_TX_HALFSYNC_EN: idle fill uses 16-bit halfsyncs instead of full syncs.
module trace_frame_tx #(
  parameter int SYNC_INTERVAL = 8,
  parameter int FRAME_BYTES   = 16
) (
  input  logic        clkIn,
  input  logic        rst,
  input  logic [7:0]  inData,
  input  logic        inValid,
  output logic        inReady,
  output logic [3:0]  traceDout,
  output logic        traceClkOut,
  output logic        syncSent,
  output logic        frameSent,
  output logic [15:0] frameCount
);
  localparam int BW = $clog2(FRAME_BYTES);
  localparam int NW = $clog2(2 * FRAME_BYTES);
  localparam logic [NW-1:0] SYNC_LAST  = NW'(7);
  localparam logic [NW-1:0] HALF_LAST  = NW'(3);
  localparam logic [NW-1:0] FRAME_LAST = NW'(2 * FRAME_BYTES - 1);

  typedef enum logic [1:0] {SYNC, FRAME, HALF} state_t;

`ifdef TRACE_TX_HALFSYNC_EN
  localparam state_t IDLE_WORD = HALF;
`else
  localparam state_t IDLE_WORD = SYNC;
`endif

  state_t state_q, state_d;

  logic [7:0]    mem [2][FRAME_BYTES];
  logic [1:0]    full_q, full_d;
  logic          fill_q, rd_q, nrd;
  logic [BW-1:0] wcnt_q;
  logic          started_q;
  logic          phase_q;
  logic [NW-1:0] nib_q, last_nib;
  logic [15:0]   scnt_q, scnt_d;
  logic          accept, last_byte, word_end, eligible, interval_hit;
  logic [3:0]    nib_val;
  logic [7:0]    cur_byte;

  assign inReady   = started_q && !full_q[fill_q];
  assign accept    = inValid && inReady;
  assign last_byte = accept && (wcnt_q == BW'(FRAME_BYTES - 1));
  assign cur_byte  = mem[rd_q][nib_q[NW-1:1]];
  assign word_end  = phase_q && (nib_q == last_nib);

  // Current nibble and word length; frames go low nibble first.
  always_comb begin
    last_nib = SYNC_LAST;
    nib_val  = (nib_q == SYNC_LAST) ? 4'h7 : 4'hF;
    case (state_q)
      FRAME: begin
        last_nib = FRAME_LAST;
        nib_val  = nib_q[0] ? cur_byte[7:4] : cur_byte[3:0];
      end
      HALF: begin
        last_nib = HALF_LAST;
        nib_val  = (nib_q == HALF_LAST) ? 4'h7 : 4'hF;
      end
      default: ;
    endcase
  end

  // Word-boundary decision; a buffer filling on the boundary edge is already eligible.
  always_comb begin
    state_d      = state_q;
    scnt_d       = scnt_q;
    full_d       = full_q;
    nrd          = rd_q;
    eligible     = 1'b0;
    interval_hit = 1'b0;
    if (last_byte) full_d[fill_q] = 1'b1;
    if (word_end) begin
      if (state_q == FRAME) begin
        scnt_d       = scnt_q + 16'd1;
        nrd          = ~rd_q;
        full_d[rd_q] = 1'b0;
      end else begin
        scnt_d = '0;
      end
      eligible     = full_q[nrd] || (last_byte && (fill_q == nrd));
      interval_hit = (SYNC_INTERVAL != 0) && (scnt_d == 16'(SYNC_INTERVAL));
      if (interval_hit)  state_d = SYNC;
      else if (eligible) state_d = FRAME;
      else               state_d = IDLE_WORD;
    end
  end

  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) state_q <= SYNC;
    else      state_q <= state_d;
  end

  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) begin
      started_q   <= 1'b0;
      phase_q     <= 1'b0;
      nib_q       <= '0;
      traceDout   <= 4'h0;
      traceClkOut <= 1'b0;
      syncSent    <= 1'b0;
      frameSent   <= 1'b0;
      frameCount  <= 16'd0;
      scnt_q      <= 16'd0;
      rd_q        <= 1'b0;
      fill_q      <= 1'b0;
      wcnt_q      <= '0;
      full_q      <= 2'b00;
    end else begin
      started_q <= 1'b1;
      syncSent  <= 1'b0;
      frameSent <= 1'b0;
      scnt_q    <= scnt_d;
      full_q    <= full_d;
      // Phase 0 presents the nibble, phase 1 clocks it out.
      if (!phase_q) begin
        traceDout <= nib_val;
        phase_q   <= 1'b1;
      end else begin
        traceClkOut <= ~traceClkOut;
        phase_q     <= 1'b0;
        if (word_end) begin
          nib_q <= '0;
          rd_q  <= nrd;
          if (state_q == FRAME) begin
            frameSent  <= 1'b1;
            frameCount <= frameCount + 16'd1;
          end else begin
            syncSent <= 1'b1;
          end
        end else begin
          nib_q <= nib_q + 1'b1;
        end
      end
      if (accept) begin
        if (last_byte) begin
          wcnt_q <= '0;
          fill_q <= ~fill_q;
        end else begin
          wcnt_q <= wcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (accept) mem[fill_q][wcnt_q] <= inData;
  end

endmodule
